// File: rtl/vector_pkg.sv
// Shared vector-unit definitions.
// Holds the sequencer state encoding, the element-width encodings, the fixed
// register-word size and register-address width, and the VLMAX and byte-count
// helpers. The CSR block uses the same VLMAX helper.
package vector_pkg;

  // Bytes per vector register word.
  localparam int VLENB   = 4;
  // Register-address width for the 32-entry vector register file.
  localparam int VREG_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    SEW_8    = 2'd0,
    SEW_16   = 2'd1,
    SEW_32   = 2'd2,
    SEW_RSVD = 2'd3
  } sew_t;

  // Elements per register times the group size.
  // The reserved vsew encoding yields 0.
  function automatic logic [5:0] vlmax_f(input logic [1:0] vsew,
                                         input logic [1:0] vlmul);
    logic [5:0] epr;
    epr = 6'd4 >> vsew;
    return epr << vlmul;
  endfunction

  // Bytes touched by the instruction, with vl clamped to VLMAX.
  // The result is at most 32, because VLMAX bytes equals VLENB << vlmul.
  function automatic logic [6:0] seq_bytes_f(input logic [4:0] vl,
                                             input logic [1:0] vsew,
                                             input logic [1:0] vlmul);
    logic [5:0] vlmax;
    logic [5:0] evl;
    vlmax = vlmax_f(vsew, vlmul);
    evl   = ({1'b0, vl} > vlmax) ? vlmax : {1'b0, vl};
    return {1'b0, evl} << vsew;
  endfunction

endpackage

// File: rtl/vector_elem_sequencer_tail_mask_gen.sv
// Tail byte-enable generator.
// i_rem     : bytes still to be processed, counted from this beat's word onward
// o_byte_en : active byte lanes of the current 4-byte word
// Every lane is active when at least one full word remains. Otherwise the
// low i_rem lanes are active.
module tail_mask_gen (
  input  logic [6:0] i_rem,
  output logic [3:0] o_byte_en
);

  always_comb begin
    o_byte_en = 4'hF;
    if (i_rem < 7'd4) begin
      case (i_rem[1:0])
        2'd0:    o_byte_en = 4'h0;
        2'd1:    o_byte_en = 4'h1;
        2'd2:    o_byte_en = 4'h3;
        default: o_byte_en = 4'h7;
      endcase
    end
  end

endmodule

// File: rtl/vector_elem_sequencer.sv
// Vector element sequencer.
// Accepts one vector instruction from decode and latches its operands. It
// then issues one beat per 4-byte register word to the register file and ALU.
// Ports:
//   clk, n_reset               clock; asynchronous active-low reset
//   start_valid / start_ready  instruction handshake (ready only in IDLE)
//   vl, vsew, vlmul            CSR values, sampled at start
//   vd/vs1/vs2_base            base register numbers, sampled at start
//   flush                      synchronous abort, returns to IDLE
//   beat_valid / beat_ready    beat handshake toward the datapath
//   vd/vs1/vs2_addr            register addresses of the current beat
//   elem_base                  index of the first element in the beat
//   byte_en                    active bytes of the beat's word
//   first_beat, last_beat      beat-position flags
//   done, sew_err              completion pulse; sew_err qualifies done
module vector_elem_sequencer
  import vector_pkg::*;
(
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [4:0]         vl,
  input  logic [1:0]         vsew,
  input  logic [1:0]         vlmul,
  input  logic [VREG_AW-1:0] vd_base,
  input  logic [VREG_AW-1:0] vs1_base,
  input  logic [VREG_AW-1:0] vs2_base,
  input  logic               flush,
  output logic               beat_valid,
  input  logic               beat_ready,
  output logic [VREG_AW-1:0] vd_addr,
  output logic [VREG_AW-1:0] vs1_addr,
  output logic [VREG_AW-1:0] vs2_addr,
  output logic [4:0]         elem_base,
  output logic [3:0]         byte_en,
  output logic               first_beat,
  output logic               last_beat,
  output logic               done,
  output logic               sew_err
);

  // Control state
  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic [2:0] r_beat_idx;
  logic [2:0] w_beat_idx_nxt;
  logic       r_sew_err;
  logic       w_load;

  // Operands latched at instruction start
  logic [1:0]         r_vsew;
  logic [VREG_AW-1:0] r_vd_base;
  logic [VREG_AW-1:0] r_vs1_base;
  logic [VREG_AW-1:0] r_vs2_base;
  logic [6:0]         r_bytes;
  logic [2:0]         r_last_idx;

  // Decode of the incoming instruction
  logic [6:0] w_bytes;
  logic [2:0] w_last_idx;

  // Decode of the current beat
  logic               w_run;
  logic               w_is_last;
  logic [6:0]         w_rem;
  logic [3:0]         w_byte_en;
  logic [4:0]         w_elem_base;
  logic [VREG_AW-1:0] w_beat_off;

  assign w_bytes = seq_bytes_f(vl, vsew, vlmul);
  // nbeats - 1 = (bytes - 1) / VLENB. Only used when bytes >= 1, because
  // vl = 0 and reserved vsew go directly to DONE.
  assign w_last_idx = 3'((w_bytes - 7'd1) / 7'(VLENB));

  assign w_run      = (r_state == RUN);
  assign w_is_last  = (r_beat_idx == r_last_idx);
  assign w_rem      = r_bytes - 7'(VLENB * r_beat_idx);
  assign w_beat_off = VREG_AW'(r_beat_idx);

  // Elements per word are 4 >> vsew, so the multiply reduces to a shift.
  always_comb begin
    case (r_vsew)
      SEW_8:   w_elem_base = {r_beat_idx, 2'b00};
      SEW_16:  w_elem_base = {1'b0, r_beat_idx, 1'b0};
      default: w_elem_base = {2'b00, r_beat_idx};
    endcase
  end

  tail_mask_gen u_tail_mask_gen (
    .i_rem     (w_rem),
    .o_byte_en (w_byte_en)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_idx_nxt = r_beat_idx;
    w_load         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_valid) begin
          w_load         = 1'b1;
          w_beat_idx_nxt = 3'd0;
          if (vsew == SEW_RSVD || vl == 5'd0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (beat_ready) begin
          if (w_is_last) begin
            w_state_nxt = DONE;
          end else begin
            w_beat_idx_nxt = r_beat_idx + 3'd1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // flush overrides both a start and a beat handshake in the same cycle.
    if (flush) begin
      w_state_nxt    = IDLE;
      w_beat_idx_nxt = r_beat_idx;
      w_load         = 1'b0;
    end
  end

  // Outputs are decoded from registered state only. Beat fields read zero
  // outside RUN, so they show their reset values whenever no beat is offered.
  always_comb begin
    start_ready = (r_state == IDLE);
    done        = (r_state == DONE);
    sew_err     = (r_state == DONE) && r_sew_err;
    beat_valid  = w_run;
    vd_addr     = '0;
    vs1_addr    = '0;
    vs2_addr    = '0;
    elem_base   = '0;
    byte_en     = '0;
    first_beat  = 1'b0;
    last_beat   = 1'b0;
    if (w_run) begin
      vd_addr    = r_vd_base + w_beat_off;
      vs1_addr   = r_vs1_base + w_beat_off;
      vs2_addr   = r_vs2_base + w_beat_off;
      elem_base  = w_elem_base;
      byte_en    = w_byte_en;
      first_beat = (r_beat_idx == 3'd0);
      last_beat  = w_is_last;
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_beat_idx <= 3'd0;
      r_sew_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_idx <= w_beat_idx_nxt;
      if (w_load) begin
        r_sew_err <= (vsew == SEW_RSVD);
      end
    end
  end

  // Operand registers. They need no reset because every output that reads
  // them is masked outside RUN.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_vsew     <= vsew;
      r_vd_base  <= vd_base;
      r_vs1_base <= vs1_base;
      r_vs2_base <= vs2_base;
      r_bytes    <= w_bytes;
      r_last_idx <= w_last_idx;
    end
  end

endmodule

// File: tb/tb_vector_elem_sequencer.sv
// Testbench for vector_elem_sequencer. A reference model derives each
// instruction's expected beat list from element counts and byte arithmetic.
module tb_vector_elem_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       start_valid;
  logic       start_ready;
  logic [4:0] vl;
  logic [1:0] vsew;
  logic [1:0] vlmul;
  logic [4:0] vd_base, vs1_base, vs2_base;
  logic       flush;
  logic       beat_valid;
  logic       beat_ready;
  logic [4:0] vd_addr, vs1_addr, vs2_addr;
  logic [4:0] elem_base;
  logic [3:0] byte_en;
  logic       first_beat, last_beat, done, sew_err;

  int errors = 0;
  int checks = 0;

  // Reference beat list for the instruction under test
  int m_nb;
  int e_vd[8], e_vs1[8], e_vs2[8], e_elem[8], e_be[8];

  always #5 clk = ~clk;

  vector_elem_sequencer dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .vl          (vl),
    .vsew        (vsew),
    .vlmul       (vlmul),
    .vd_base     (vd_base),
    .vs1_base    (vs1_base),
    .vs2_base    (vs2_base),
    .flush       (flush),
    .beat_valid  (beat_valid),
    .beat_ready  (beat_ready),
    .vd_addr     (vd_addr),
    .vs1_addr    (vs1_addr),
    .vs2_addr    (vs2_addr),
    .elem_base   (elem_base),
    .byte_en     (byte_en),
    .first_beat  (first_beat),
    .last_beat   (last_beat),
    .done        (done),
    .sew_err     (sew_err)
  );

  function automatic logic [27:0] obs();
    return {beat_valid, vd_addr, vs1_addr, vs2_addr, elem_base, byte_en,
            first_beat, last_beat, done};
  endfunction

  // Behavioural model: elements per word, clamp to VLMAX, count bytes,
  // then split the byte count into 4-byte words.
  task automatic model_build(input int a_vl, input int a_sew, input int a_lmul,
                             input int a_vd, input int a_vs1, input int a_vs2);
    int epr, vlmax, evl, bytes, rem;
    m_nb = 0;
    if (a_vl == 0 || a_sew == 3) return;
    epr   = 4 / (1 << a_sew);
    vlmax = epr * (1 << a_lmul);
    evl   = (a_vl < vlmax) ? a_vl : vlmax;
    bytes = evl * (1 << a_sew);
    m_nb  = (bytes + 3) / 4;
    for (int k = 0; k < m_nb; k++) begin
      e_vd[k]   = (a_vd + k) % 32;
      e_vs1[k]  = (a_vs1 + k) % 32;
      e_vs2[k]  = (a_vs2 + k) % 32;
      e_elem[k] = k * epr;
      rem       = bytes - 4 * k;
      e_be[k]   = (rem >= 4) ? 15 : ((1 << rem) - 1);
    end
  endtask

  // Runs one instruction. stall_mode: 0 = always ready, 1 = 1,0,0,1 pattern,
  // 2 = random. A flush is raised together with start_valid while beat
  // flush_at is on offer (-1 = never).
  task automatic run_seq(input int a_vl, input int a_sew, input int a_lmul,
                         input int a_vd, input int a_vs1, input int a_vs2,
                         input int stall_mode, input int flush_at,
                         input string tag);
    int k, p, cyc;
    logic rdy;
    logic [27:0] exp_v, got_v;
    logic [2:0] exp3, got3;
    model_build(a_vl, a_sew, a_lmul, a_vd, a_vs1, a_vs2);
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s start_ready: got %b expected 1", tag, start_ready);
    end
    start_valid = 1'b1;
    vl = 5'(a_vl); vsew = 2'(a_sew); vlmul = 2'(a_lmul);
    vd_base = 5'(a_vd); vs1_base = 5'(a_vs1); vs2_base = 5'(a_vs2);
    @(negedge clk);
    start_valid = 1'b0;
    // Scramble the CSR and base inputs; the instruction must not see them.
    vl = 5'($urandom); vsew = 2'($urandom); vlmul = 2'($urandom);
    vd_base = 5'($urandom); vs1_base = 5'($urandom); vs2_base = 5'($urandom);
    if (m_nb == 0) begin
      exp3 = {1'b0, 1'b1, (a_sew == 3)};
      got3 = {beat_valid, done, sew_err};
      checks++;
      if (got3 !== exp3) begin
        errors++;
        $display("FAIL %s early done {valid,done,sew_err}: got %b expected %b", tag, got3, exp3);
      end
      @(negedge clk);
      got3 = {beat_valid, done, start_ready};
      checks++;
      if (got3 !== 3'b001) begin
        errors++;
        $display("FAIL %s after done {valid,done,ready}: got %b expected 001", tag, got3);
      end
      return;
    end
    k = 0; p = 0; cyc = 0;
    while (k < m_nb && cyc < 200) begin
      exp_v = {1'b1, 5'(e_vd[k]), 5'(e_vs1[k]), 5'(e_vs2[k]), 5'(e_elem[k]),
               4'(e_be[k]), (k == 0), (k == m_nb - 1), 1'b0};
      got_v = obs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s beat%0d: got %h expected %h", tag, k, got_v, exp_v);
      end
      if (k == flush_at) begin
        flush = 1'b1; start_valid = 1'b1; beat_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; start_valid = 1'b0; beat_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
          got3 = {beat_valid, done, start_ready};
          checks++;
          if (got3 !== 3'b001) begin
            errors++;
            $display("FAIL %s flush cycle%0d {valid,done,ready}: got %b expected 001", tag, i, got3);
          end
          if (i == 0) @(negedge clk);
        end
        return;
      end
      case (stall_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((p % 4) == 0) || ((p % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      p++;
      beat_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    beat_ready = 1'b0;
    if (k < m_nb) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: got beat %0d expected %0d", tag, k, m_nb);
      return;
    end
    got3 = {beat_valid, done, sew_err};
    checks++;
    if (got3 !== 3'b010) begin
      errors++;
      $display("FAIL %s done {valid,done,sew_err}: got %b expected 010", tag, got3);
    end
    @(negedge clk);
    got3 = {beat_valid, done, start_ready};
    checks++;
    if (got3 !== 3'b001) begin
      errors++;
      $display("FAIL %s after done {valid,done,ready}: got %b expected 001", tag, got3);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0; start_valid = 1'b0; flush = 1'b0; beat_ready = 1'b0;
    vl = '0; vsew = '0; vlmul = '0; vd_base = '0; vs1_base = '0; vs2_base = '0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({obs(), sew_err, start_ready} !== {28'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset outputs: got %h/%b/%b expected 0000000/0/1", obs(), sew_err, start_ready);
    end
  endtask

  task automatic test_basic();
    run_seq(8, 0, 1, 4, 8, 12, 0, -1, "basic");
  endtask

  task automatic test_tail();
    run_seq(3, 1, 1, 1, 2, 3, 0, -1, "tail");
  endtask

  task automatic test_no_beat();
    run_seq(0, 0, 0, 5, 6, 7, 0, -1, "vl0");
    run_seq(5, 3, 2, 5, 6, 7, 0, -1, "rsvd");
  endtask

  task automatic test_stall_wrap();
    run_seq(8, 2, 3, 30, 17, 25, 1, -1, "stallwrap");
  endtask

  task automatic test_flush();
    run_seq(8, 2, 3, 30, 17, 25, 1, 2, "flush");
    run_seq(8, 0, 1, 4, 8, 12, 0, -1, "postflush");
  endtask

  task automatic test_clamp();
    run_seq(20, 2, 0, 9, 10, 11, 0, -1, "clamp");
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start_valid = 1'b1; vl = 5'd8; vsew = 2'd2; vlmul = 2'd3;
    vd_base = 5'd3; vs1_base = 5'd4; vs2_base = 5'd5;
    @(negedge clk);
    start_valid = 1'b0; beat_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (beat_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrun active: got %b expected 1", beat_valid);
    end
    n_reset = 1'b0;
    #1;
    checks++;
    if ({obs(), sew_err} !== 29'h0) begin
      errors++;
      $display("FAIL midrun in reset: got %h expected 0", {obs(), sew_err});
    end
    @(negedge clk);
    n_reset = 1'b1;
    beat_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({obs(), sew_err, start_ready} !== {29'h0, 1'b1}) begin
        errors++;
        $display("FAIL midrun after release%0d: got %h expected 1", i, {obs(), sew_err, start_ready});
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_seq($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              2, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail();
    test_no_beat();
    test_stall_wrap();
    test_flush();
    test_clamp();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_elem_sequencer.md
# vector_elem_sequencer

Sequences one vector instruction across the 32-bit vector datapath. It latches the current vl/vsew/vlmul and the base register numbers at instruction start, then issues one beat per register word (VLENB = 4 bytes). Each beat carries the register addresses, starting element index and tail byte enables. It sits between the APU-interface decode logic and the vector register file/ALU, downstream of the vector CSR block that supplies vl, vsew and vlmul.

## Interface
- No parameters. VLENB = 4 and the register-file depth of 32 are fixed constants from `vector_pkg`.
- clk  in  1  clock
- n_reset  in  1  reset, asynchronous, active-low
- start_valid  in  1  decode requests sequencing of one instruction
- start_ready  out  1  sequencer can accept an instruction (high only in IDLE)
- vl  in  5  current vector length, from the CSR block
- vsew  in  2  element width: 0 = 8b, 1 = 16b, 2 = 32b, 3 = reserved
- vlmul  in  2  register group size: 1, 2, 4 or 8 registers
- vd_base, vs1_base, vs2_base  in  5 each  base register numbers
- flush  in  1  synchronous abort of the current instruction
- beat_valid  out  1  a beat is presented to the datapath
- beat_ready  in  1  datapath accepts the beat
- vd_addr, vs1_addr, vs2_addr  out  5 each  register addresses for this beat
- elem_base  out  5  index of the first element in this beat
- byte_en  out  4  active bytes of this beat's word
- first_beat, last_beat  out  1 each  beat-position flags
- done  out  1  one-cycle pulse when the instruction completes
- sew_err  out  1  qualifies `done`: the instruction had reserved vsew

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid, latch vl, vsew, vlmul and the three base registers; clear beat_idx.
  - Next state: DONE with sew_err = 1 if vsew = 3; DONE if vl = 0; otherwise RUN.
- Byte count:
  - bytes = vl << vsew, computed 7 bits wide.
  - VLMAX = (4 >> vsew) << vlmul.
  - If vl > VLMAX, use VLMAX for the byte count (clamp, no error).
  - nbeats = ceil(bytes / 4), range 1..8.
- RUN:
  - beat_valid = 1.
  - Register addresses: xx_addr = xx_base + beat_idx, modulo 32 (wraps past v31).
  - elem_base = beat_idx * (4 >> vsew).
  - Remaining bytes: rem = bytes − 4*beat_idx. byte_en = 4'hF if rem ≥ 4, else (1 << rem) − 1.
  - first_beat = (beat_idx == 0). last_beat = (beat_idx == nbeats − 1).
  - On beat_valid && beat_ready: if last_beat, go to DONE; otherwise beat_idx++.
  - While beat_ready is low, every beat output holds stable.
- DONE:
  - done = 1 for exactly one cycle; sew_err is valid in the same cycle.
  - Next state: IDLE.
- flush:
  - From any state, flush forces IDLE on the next edge.
  - No done pulse follows. beat_valid drops on the next cycle.
  - flush has priority over start_valid and beat handshakes in the same cycle.
- CSR changes during RUN or DONE have no effect, because all operands are latched.
- Reset values: state IDLE; beat_valid, done, sew_err, first_beat, last_beat = 0; all addresses, elem_base, byte_en = 0; start_ready = 1 once reset is released.

## Timing
- Start is accepted at edge T. The first beat is presented in cycle T+1; all outputs are registered or decoded from registered state.
- With beat_ready held high, beat k is accepted at edge T+1+k.
- done is asserted in the cycle after the last beat is accepted. start_ready returns the cycle after done.
- Minimum occupancy is nbeats + 2 cycles per instruction.
- vl = 0 or reserved vsew: done is asserted in cycle T+1 and no beat is issued.
- Asserting n_reset mid-RUN abandons the instruction immediately. No done pulse is produced.

## Structure
- `vector_pkg` holds:
  - `seq_state_t` enum (IDLE/RUN/DONE)
  - VLENB = 4
  - `sew_t` encodings, and a VLMAX helper function shared with the CSR block
- One sub-module, `tail_mask_gen`: combinational, takes rem[6:0] and produces byte_en[3:0].

## Test plan
- vl=8, vsew=0, vlmul=1 (2 regs), bases vd=4/vs1=8/vs2=12, beat_ready=1 → 2 beats. Beat 0: addresses 4/8/12, elem_base 0. Beat 1: addresses 5/9/13, elem_base 4. byte_en F both beats; done at T+3.
- vl=3, vsew=1, vlmul=1 → bytes=6, 2 beats; byte_en F then 3; last_beat on beat 1, elem_base 2.
- vl=0, and separately vsew=3 → no beat_valid; done at T+1; sew_err=0 and 1 respectively.
- vl=8, vsew=2, vlmul=3, vd_base=30, beat_ready toggling 1,0,0,1… → 8 beats; vd_addr 30,31,0,1…; outputs stable during stalls.
- Second test, same setup as the previous one: flush asserted at the 3rd beat together with start_valid → IDLE next cycle, no done, start_ready=1. A new instruction then runs normally.
- vl=20 with vsew=2, vlmul=0 (VLMAX=1) → clamped to 1 beat, byte_en F. In a separate run, n_reset pulsed mid-RUN → all outputs return to reset values.
